// File: rtl/typec_pkg.sv
// Shared Type-C command link definitions: packet-type codes, PID bytes, header nibbles, error causes.
// The transmitter imports this same package.
package typec_pkg;

    localparam logic [3:0] BAG_INIT   = 4'd0;
    localparam logic [3:0] BAG_ACK    = 4'd1;
    localparam logic [3:0] BAG_NAK    = 4'd2;
    localparam logic [3:0] BAG_STALL  = 4'd3;
    localparam logic [3:0] BAG_DIDX   = 4'd5;
    localparam logic [3:0] BAG_DPARAM = 4'd6;
    localparam logic [3:0] BAG_DDIDX  = 4'd7;
    localparam logic [3:0] BAG_DTYPE  = 4'b1001;

    localparam logic [7:0] PID_SYNC  = 8'h01;
    localparam logic [7:0] PID_ACK   = 8'h2D;
    localparam logic [7:0] PID_NAK   = 8'hA5;
    localparam logic [7:0] PID_STALL = 8'hE1;
    localparam logic [7:0] PID_CMD   = 8'h1E;
    localparam logic [7:0] PID_STAT  = 8'hD2;
    localparam logic [7:0] PID_DATA0 = 8'h96;
    localparam logic [7:0] PID_DATA1 = 8'h5A;

    localparam logic [3:0] HEAD_DIDX   = 4'h9;
    localparam logic [3:0] HEAD_DPARAM = 4'h5;
    localparam logic [3:0] HEAD_DDIDX  = 4'h1;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_PID     = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_HEAD    = 3'd3;
    localparam logic [2:0] ERR_CRC     = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    typedef enum logic [3:0] {
        ST_IDLE, ST_WAIT, ST_HUNT, ST_PID, ST_LEN0,
        ST_LEN1, ST_CMD, ST_CRC, ST_COMMIT, ST_DONE
    } rx_state_e;

    // BAG_INIT doubles as "not a handshake PID" / "not a known header".
    function automatic logic [3:0] pid_to_bag(input logic [7:0] pid);
        case (pid)
            PID_ACK:   return BAG_ACK;
            PID_NAK:   return BAG_NAK;
            PID_STALL: return BAG_STALL;
            default:   return BAG_INIT;
        endcase
    endfunction

    function automatic logic [3:0] head_to_bag(input logic [3:0] head);
        case (head)
            HEAD_DIDX:   return BAG_DIDX;
            HEAD_DPARAM: return BAG_DPARAM;
            HEAD_DDIDX:  return BAG_DDIDX;
            default:     return BAG_INIT;
        endcase
    endfunction

endpackage

// File: rtl/typecs_rx_if.sv
// Receiver-side link and controller handshake bundle for typecs_rx.
interface typecs_rx_if;
    logic       fs;
    logic       fd;
    logic [7:0] com_rxd;
    logic [3:0] btype;
    logic [3:0] didx;
    logic [3:0] freq;
    logic [3:0] ddidx;
    logic       err;
    logic [2:0] err_code;

    modport slave (
        input  fs, com_rxd,
        output fd, btype, didx, freq, ddidx, err, err_code
    );

    modport master (
        output fs, com_rxd,
        input  fd, btype, didx, freq, ddidx, err, err_code
    );
endinterface

// File: rtl/crc5.sv
// CRC5 (poly x^5+x^2+1, seed 0x1F, LSB first) over bytes presented while enable is high.
// Re-seeds on every cycle enable is low, so dout holds the result for one cycle after the last byte.
module crc5 (
    input  logic       clk,
    input  logic       enable,
    input  logic [7:0] din,
    output logic [4:0] dout
);
    function automatic logic [4:0] crc_byte(input logic [4:0] c_in, input logic [7:0] d);
        logic [4:0] c;
        logic       fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0};
            if (fb) c = c ^ 5'h05;
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (enable) dout <= crc_byte(dout, din);
        else        dout <= 5'h1F;
    end
endmodule

// File: rtl/typecs_rx.sv
// Type-C command link packet receiver: SYNC hunt, PID/length/header decode, CRC5 check, field commit.
//
// state  | meaning
// IDLE   | leaving reset
// WAIT   | waiting for fs from the controller
// HUNT   | scanning for SYNC, timeout counter running
// PID    | decoding the packet identifier
// LEN0   | expecting length byte 0x00
// LEN1   | expecting length byte 0x01
// CMD    | decoding command header, feeding crc5
// CRC    | comparing received byte with crc5
// COMMIT | copying pending type/field to outputs
// DONE   | fd high until fs drops
module typecs_rx
    import typec_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    typecs_rx_if.slave bus
);
    rx_state_e  state, state_nxt;
    logic [15:0] cnt;
    logic [3:0]  pend_type, pend_field;
    logic [3:0]  btype, didx, freq, ddidx;
    logic        err;
    logic [2:0]  err_code;
    logic        err_set;
    logic [2:0]  err_val;
    logic [7:0]  rxd;
    logic        crc_en;
    logic [4:0]  crc_dout;

    assign rxd    = bus.com_rxd;
    assign crc_en = (state == ST_CMD);

    crc5 u_crc5 (
        .clk    (clk),
        .enable (crc_en),
        .din    (rxd),
        .dout   (crc_dout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_val   = ERR_NONE;
        case (state)
            ST_IDLE: state_nxt = ST_WAIT;
            ST_WAIT: if (bus.fs) state_nxt = ST_HUNT;
            ST_HUNT: begin
                if (rxd == PID_SYNC) begin
                    state_nxt = ST_PID;
                end else if (cnt == TIMEOUT - 16'd1) begin
                    state_nxt = ST_DONE;
                    err_set   = 1'b1;
                    err_val   = ERR_TIMEOUT;
                end
            end
            ST_PID: begin
                if (pid_to_bag(rxd) != BAG_INIT) begin
                    state_nxt = ST_COMMIT;
                end else if (rxd == PID_CMD) begin
                    state_nxt = ST_LEN0;
                end else begin
                    state_nxt = ST_DONE;
                    err_set   = 1'b1;
                    err_val   = ERR_PID;
                end
            end
            ST_LEN0, ST_LEN1: begin
                if (rxd == ((state == ST_LEN0) ? 8'h00 : 8'h01)) begin
                    state_nxt = (state == ST_LEN0) ? ST_LEN1 : ST_CMD;
                end else begin
                    state_nxt = ST_DONE;
                    err_set   = 1'b1;
                    err_val   = ERR_LEN;
                end
            end
            ST_CMD: begin
                if (head_to_bag(rxd[7:4]) != BAG_INIT) begin
                    state_nxt = ST_CRC;
                end else begin
                    state_nxt = ST_DONE;
                    err_set   = 1'b1;
                    err_val   = ERR_HEAD;
                end
            end
            ST_CRC: begin
                if (rxd == {3'b000, crc_dout}) begin
                    state_nxt = ST_COMMIT;
                end else begin
                    state_nxt = ST_DONE;
                    err_set   = 1'b1;
                    err_val   = ERR_CRC;
                end
            end
            ST_COMMIT: state_nxt = ST_DONE;
            ST_DONE:   if (!bus.fs) state_nxt = ST_WAIT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            pend_type  <= BAG_INIT;
            pend_field <= '0;
            btype      <= BAG_INIT;
            didx       <= '0;
            freq       <= '0;
            ddidx      <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            if (state == ST_WAIT && bus.fs) begin
                cnt      <= '0;
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
            // Cannot wrap: HUNT is left at TIMEOUT-1 at the latest.
            if (state == ST_HUNT) cnt <= cnt + 16'd1;
            if (state == ST_PID)  pend_type <= pid_to_bag(rxd);
            if (state == ST_CMD) begin
                pend_type  <= head_to_bag(rxd[7:4]);
                pend_field <= rxd[3:0];
            end
            if (err_set) begin
                err      <= 1'b1;
                err_code <= err_val;
            end
            if (state == ST_COMMIT) begin
                btype <= pend_type;
                case (pend_type)
                    BAG_DIDX:   didx  <= pend_field;
                    BAG_DPARAM: freq  <= pend_field;
                    BAG_DDIDX:  ddidx <= pend_field;
                    default:    ;
                endcase
            end
        end
    end

    assign bus.fd       = (state == ST_DONE);
    assign bus.btype    = btype;
    assign bus.didx     = didx;
    assign bus.freq     = freq;
    assign bus.ddidx    = ddidx;
    assign bus.err      = err;
    assign bus.err_code = err_code;
endmodule

// File: tb/tb_typecs_rx.sv
// Self-checking bench for typecs_rx: directed scenarios plus randomized packets against a packet-level model.
module tb_typecs_rx;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [3:0] m_btype, m_didx, m_freq, m_ddidx;

    typecs_rx_if bus();

    typecs_rx #(.TIMEOUT(16'd8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // CRC5 as polynomial division of the byte (LSB first) with register preset to all ones.
    function automatic logic [7:0] crc_ref(input logic [7:0] d);
        int r = 31;
        for (int i = 0; i < 8; i++) begin
            int b   = (int'(d) >> i) & 1;
            int top = (r >> 4) & 1;
            r = (r << 1) & 31;
            if ((top ^ b) != 0) r = r ^ 5;
        end
        return 8'(r);
    endfunction

    function automatic bq_t mk_cmd(input logic [7:0] l0, input logic [7:0] l1,
                                   input logic [7:0] hdr, input logic [7:0] crc);
        bq_t q;
        q.push_back(8'h1E); q.push_back(l0); q.push_back(l1);
        q.push_back(hdr);   q.push_back(crc);
        return q;
    endfunction

    // Packet-level reference: returns expected error code and updates the expected fields.
    function automatic logic [2:0] model_pkt(input bq_t body);
        logic [7:0] pid = body[0];
        logic [7:0] hdr;
        logic [3:0] t;
        if (pid == 8'h2D) begin m_btype = 4'd1; return 3'd0; end
        if (pid == 8'hA5) begin m_btype = 4'd2; return 3'd0; end
        if (pid == 8'hE1) begin m_btype = 4'd3; return 3'd0; end
        if (pid != 8'h1E) return 3'd1;
        if (body[1] != 8'h00 || body[2] != 8'h01) return 3'd2;
        hdr = body[3];
        if (hdr[7:4] == 4'h9)      t = 4'd5;
        else if (hdr[7:4] == 4'h5) t = 4'd6;
        else if (hdr[7:4] == 4'h1) t = 4'd7;
        else return 3'd3;
        if (body[4] != crc_ref(hdr)) return 3'd4;
        m_btype = t;
        if (t == 4'd5) m_didx = hdr[3:0];
        if (t == 4'd6) m_freq = hdr[3:0];
        if (t == 4'd7) m_ddidx = hdr[3:0];
        return 3'd0;
    endfunction

    // Streams 00,00,SYNC,body with fs high; lat = clock edges from SYNC until fd, -1 if never.
    task automatic run_pkt(input bq_t body, input int drop_at, output int lat);
        bq_t strm;
        strm.push_back(8'h00); strm.push_back(8'h00); strm.push_back(8'h01);
        foreach (body[k]) strm.push_back(body[k]);
        lat    = -1;
        bus.fs = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == drop_at) bus.fs = 1'b0;
            bus.com_rxd = (i < strm.size()) ? strm[i] : 8'h00;
            @(posedge clk); #1;
            if (bus.fd) begin
                lat = i - 1;
                break;
            end
        end
        bus.com_rxd = 8'h00;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL pkt_fd_wait: fd=0 required=1 within 40 cycles");
        end
    endtask

    task automatic end_pkt();
        bus.fs = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.fs = 1'b0; bus.com_rxd = 8'h00; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.fd, bus.btype, bus.didx, bus.freq, bus.ddidx, bus.err, bus.err_code} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got fd=%0b btype=%0d didx=%0d freq=%0d ddidx=%0d err=%0b code=%0d required all 0",
                     bus.fd, bus.btype, bus.didx, bus.freq, bus.ddidx, bus.err, bus.err_code);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        m_btype = 0; m_didx = 0; m_freq = 0; m_ddidx = 0;
    endtask

    task automatic test_handshake();
        int lat;
        bq_t b;
        b.push_back(8'h2D);
        run_pkt(b, -1, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL hs_latency: got %0d required 3", lat); end
        checks++;
        if (bus.btype !== 4'd1 || bus.err !== 1'b0) begin
            errors++; $display("FAIL hs_ack: btype=%0d err=%0b required btype=1 err=0", bus.btype, bus.err);
        end
        checks++;
        if ({bus.didx, bus.freq, bus.ddidx} !== 12'd0) begin
            errors++; $display("FAIL hs_fields: didx=%0d freq=%0d ddidx=%0d required 0", bus.didx, bus.freq, bus.ddidx);
        end
        end_pkt();
    endtask

    task automatic test_cmd_didx();
        int lat;
        run_pkt(mk_cmd(8'h00, 8'h01, 8'h93, crc_ref(8'h93)), -1, lat);
        checks++;
        if (bus.fd !== 1'b1 || bus.btype !== 4'd5 || bus.didx !== 4'd3 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL cmd_didx: fd=%0b btype=%0d didx=%0d err=%0b required 1/5/3/0", bus.fd, bus.btype, bus.didx, bus.err);
        end
        end_pkt();
        checks++;
        if (bus.fd !== 1'b0) begin errors++; $display("FAIL cmd_didx_release: fd=%0b required 0", bus.fd); end
    endtask

    task automatic test_cmd_dparam();
        int lat;
        run_pkt(mk_cmd(8'h00, 8'h01, 8'h57, crc_ref(8'h57)), -1, lat);
        checks++;
        if (bus.btype !== 4'd6 || bus.freq !== 4'd7 || bus.didx !== 4'd3 || bus.ddidx !== 4'd0) begin
            errors++;
            $display("FAIL cmd_dparam: btype=%0d freq=%0d didx=%0d ddidx=%0d required 6/7/3/0", bus.btype, bus.freq, bus.didx, bus.ddidx);
        end
        end_pkt();
    endtask

    task automatic test_crc_error();
        int lat;
        run_pkt(mk_cmd(8'h00, 8'h01, 8'h12, crc_ref(8'h12) ^ 8'h01), -1, lat);
        checks++;
        if (bus.err !== 1'b1 || bus.err_code !== 3'd4) begin
            errors++; $display("FAIL crc_err: err=%0b code=%0d required 1/4", bus.err, bus.err_code);
        end
        checks++;
        if (bus.btype !== 4'd6 || bus.freq !== 4'd7 || bus.ddidx !== 4'd0) begin
            errors++; $display("FAIL crc_hold: btype=%0d freq=%0d ddidx=%0d required 6/7/0", bus.btype, bus.freq, bus.ddidx);
        end
        end_pkt();
    endtask

    task automatic test_bad_fields();
        int  lat;
        bq_t b;
        b.push_back(8'h5A);
        run_pkt(b, -1, lat);
        checks++;
        if (bus.err_code !== 3'd1 || bus.err !== 1'b1) begin
            errors++; $display("FAIL bad_pid: code=%0d err=%0b required 1/1", bus.err_code, bus.err);
        end
        end_pkt();
        run_pkt(mk_cmd(8'h00, 8'h02, 8'h93, 8'h00), -1, lat);
        checks++;
        if (bus.err_code !== 3'd2) begin errors++; $display("FAIL bad_len: code=%0d required 2", bus.err_code); end
        end_pkt();
        run_pkt(mk_cmd(8'h00, 8'h01, 8'hF3, 8'h00), -1, lat);
        checks++;
        if (bus.err_code !== 3'd3) begin errors++; $display("FAIL bad_head: code=%0d required 3", bus.err_code); end
        checks++;
        if (bus.btype !== 4'd6 || bus.didx !== 4'd3) begin
            errors++; $display("FAIL bad_hold: btype=%0d didx=%0d required 6/3", bus.btype, bus.didx);
        end
        end_pkt();
    endtask

    task automatic test_timeout();
        int n = 0;
        bus.fs = 1'b1; bus.com_rxd = 8'h00;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            n++;
            if (bus.fd) break;
        end
        // One cycle in WAIT, then eight in HUNT.
        checks++;
        if (n !== 9 || bus.fd !== 1'b1) begin
            errors++; $display("FAIL timeout_latency: fd=%0b after %0d cycles required fd=1 after 9", bus.fd, n);
        end
        checks++;
        if (bus.err !== 1'b1 || bus.err_code !== 3'd5) begin
            errors++; $display("FAIL timeout_code: err=%0b code=%0d required 1/5", bus.err, bus.err_code);
        end
        end_pkt();
    endtask

    task automatic test_fs_drop();
        int lat;
        int hi = 1;
        // fs drops while the PID byte is on the wire; packet still completes, DONE lasts one cycle.
        run_pkt(mk_cmd(8'h00, 8'h01, 8'h9A, crc_ref(8'h9A)), 3, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.fd) hi++;
        end
        checks++;
        if (hi !== 1) begin errors++; $display("FAIL fs_drop_fd: fd high %0d cycles required 1", hi); end
        checks++;
        if (bus.btype !== 4'd5 || bus.didx !== 4'hA || bus.err !== 1'b0) begin
            errors++; $display("FAIL fs_drop_data: btype=%0d didx=%0d err=%0b required 5/10/0", bus.btype, bus.didx, bus.err);
        end
        m_btype = 4'd5; m_didx = 4'hA; m_freq = 4'd7; m_ddidx = 4'd0;
    endtask

    task automatic test_random();
        logic [3:0] heads[3] = '{4'h9, 4'h5, 4'h1};
        logic [7:0] hsp[3]   = '{8'h2D, 8'hA5, 8'hE1};
        for (int it = 0; it < 30; it++) begin
            bq_t        body;
            logic [7:0] hdr, x, y;
            logic [2:0] ec;
            int         lat;
            int         kind = int'($urandom_range(0, 5));
            hdr = {heads[$urandom_range(0, 2)], 4'($urandom_range(0, 15))};
            case (kind)
                0: body.push_back(hsp[$urandom_range(0, 2)]);
                1: body = mk_cmd(8'h00, 8'h01, hdr, crc_ref(hdr));
                2: body = mk_cmd(8'h00, 8'h01, hdr, crc_ref(hdr) ^ (8'h01 << $urandom_range(0, 7)));
                3: begin
                    do x = 8'($urandom_range(0, 255));
                    while (x == 8'h2D || x == 8'hA5 || x == 8'hE1 || x == 8'h1E);
                    body.push_back(x);
                end
                4: begin
                    do begin x = 8'($urandom_range(0, 3)); y = 8'($urandom_range(0, 3)); end
                    while (x == 8'h00 && y == 8'h01);
                    body = mk_cmd(x, y, hdr, crc_ref(hdr));
                end
                default: begin
                    do hdr[7:4] = 4'($urandom_range(0, 15));
                    while (hdr[7:4] == 4'h9 || hdr[7:4] == 4'h5 || hdr[7:4] == 4'h1);
                    body = mk_cmd(8'h00, 8'h01, hdr, crc_ref(hdr));
                end
            endcase
            ec = model_pkt(body);
            run_pkt(body, -1, lat);
            checks++;
            if (bus.err !== (ec != 3'd0) || bus.err_code !== ec) begin
                errors++;
                $display("FAIL rand_err[%0d]: err=%0b code=%0d required %0b/%0d", it, bus.err, bus.err_code, ec != 3'd0, ec);
            end
            checks++;
            if (bus.btype !== m_btype || bus.didx !== m_didx || bus.freq !== m_freq || bus.ddidx !== m_ddidx) begin
                errors++;
                $display("FAIL rand_fields[%0d]: btype=%0d didx=%0d freq=%0d ddidx=%0d required %0d/%0d/%0d/%0d",
                         it, bus.btype, bus.didx, bus.freq, bus.ddidx, m_btype, m_didx, m_freq, m_ddidx);
            end
            end_pkt();
        end
    endtask

    task automatic test_reset_mid_packet();
        int  lat;
        bq_t b;
        logic [7:0] pre[6] = '{8'h00, 8'h00, 8'h01, 8'h1E, 8'h00, 8'h01};
        bus.fs = 1'b1;
        foreach (pre[i]) begin
            bus.com_rxd = pre[i];
            @(posedge clk); #1;
        end
        bus.com_rxd = 8'h93;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.fd, bus.btype, bus.didx, bus.freq, bus.ddidx, bus.err, bus.err_code} !== 22'd0) begin
            errors++;
            $display("FAIL reset_mid: fd=%0b btype=%0d didx=%0d freq=%0d ddidx=%0d err=%0b code=%0d required all 0",
                     bus.fd, bus.btype, bus.didx, bus.freq, bus.ddidx, bus.err, bus.err_code);
        end
        bus.fs = 1'b0; bus.com_rxd = 8'h00;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b.push_back(8'hE1);
        run_pkt(b, -1, lat);
        checks++;
        if (lat !== 3 || bus.btype !== 4'd3 || bus.didx !== 4'd0) begin
            errors++; $display("FAIL reset_recover: lat=%0d btype=%0d didx=%0d required 3/3/0", lat, bus.btype, bus.didx);
        end
        end_pkt();
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_cmd_didx();
        test_cmd_dparam();
        test_crc_error();
        test_bad_fields();
        test_timeout();
        test_fs_drop();
        test_random();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
